vfifo_mq_ctrl: RTL
==================

Name: vfifo_mq_ctrl

Overview:
Controller that partitions one single-clock simple dual-port RAM (one write port, registered read address, one-cycle read latency) into 2^CH_BITS independent logical FIFOs.
- Each channel owns a fixed contiguous region of 2^(ADDR_WIDTH-CH_BITS) words.
- The block keeps per-channel read/write pointers, full/empty flags and fill levels.
- It drives the RAM write enable and both addresses, and tags read data with its channel.
- It sits between channel producers/consumers and the RAM instance.

Parameters:
ADDR_WIDTH, 8, total RAM address width; must be greater than CH_BITS.
CH_BITS, 2, log2 of channel count (NCH = 2^CH_BITS).
Derived: PW = ADDR_WIDTH-CH_BITS (region address width), DEPTH = 2^PW words per channel.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request for channel wr_ch
wr_ch  in  CH_BITS  write channel select
rd_en  in  1  read request for channel rd_ch
rd_ch  in  CH_BITS  read channel select
ram_we_a  out  1  RAM write enable
ram_adr_a  out  ADDR_WIDTH  RAM write address
ram_adr_b  out  ADDR_WIDTH  RAM read address (the RAM registers it)
rd_valid  out  1  RAM read data is valid this cycle
rd_ch_q  out  CH_BITS  channel of the word currently on the RAM read output
full  out  NCH  per-channel full flags
empty  out  NCH  per-channel empty flags
lvl_ch  in  CH_BITS  level query channel select
lvl  out  PW+1  fill level of channel lvl_ch (0..DEPTH)
ovf  out  1  one-cycle pulse: write rejected because the channel is full
udf  out  1  one-cycle pulse: read rejected because the channel is empty

Behaviour:
Pointers
- Per channel: wptr[c] and rptr[c], each PW+1 bits. The MSB is the wrap bit.
- empty[c] = (wptr == rptr).
- full[c] = (low PW bits equal and MSBs differ).
- All flags are registered-state-derived, i.e. combinational from the pointer registers. No look-ahead.

Write path
- wr_acc = wr_en & ~full[wr_ch].
- ram_we_a = wr_acc, combinational.
- ram_adr_a = {wr_ch, wptr[wr_ch][PW-1:0]}, driven at all times.
- On wr_acc, wptr[wr_ch] increments mod 2^(PW+1) at the clock edge.
- wr_en & full[wr_ch] gives no RAM write, no pointer change, and ovf=1 on the next cycle (registered).

Read path
- rd_acc = rd_en & ~empty[rd_ch].
- ram_adr_b = {rd_ch, rptr[rd_ch][PW-1:0]}, driven at all times.
- On rd_acc, rptr[rd_ch] increments at the edge.
- rd_valid and rd_ch_q are registered: rd_valid <= rd_acc, rd_ch_q <= rd_ch.
- The RAM output therefore carries that word in the same cycle rd_valid is high: one-cycle latency from the accepted request.
- rd_en & empty[rd_ch] gives no pointer change, rd_valid=0 next cycle, and udf=1 next cycle.

Simultaneous events
- Write and read on different channels in the same cycle: both proceed independently.
- Write and read on the same channel in the same cycle: each is judged against current flags.
  - Full channel: read accepted, write rejected (ovf).
  - Empty channel: write accepted, read rejected (udf).
  - Otherwise both are accepted and the level is unchanged.
- A write accepted in cycle t is readable from cycle t+1 onward.

Level and wrap
- lvl = wptr[lvl_ch] - rptr[lvl_ch], computed in PW+1 bits with modular arithmetic. Combinational.
- Pointer wrap at 2^(PW+1) is seamless.
- Region addresses wrap from DEPTH-1 to 0 and never cross into another channel's region.

Reset
- While rst_n=0, asynchronously:
  - all pointers = 0; rd_valid=0, rd_ch_q=0, ovf=0, udf=0
  - empty = all ones, full = 0, lvl = 0
  - ram_we_a = 0, because wr_acc is gated by rst_n
- Reset asserted mid-operation discards all queued data. A pending rd_valid is cleared immediately.
- The RAM contents are not cleared and do not need to be.

Test Plan:
- Reset, then idle -> empty=4'b1111, full=0, lvl=0 for every lvl_ch, ram_we_a=0, rd_valid=0.
- Write 0xA0..0xA3 to ch1 on consecutive cycles -> ram_adr_a = 0x40, 0x41, 0x42, 0x43 with ram_we_a=1; lvl(ch1)=4; empty=4'b1101.
  - Then read ch1 four times -> ram_adr_b 0x40..0x43; rd_valid high one cycle after each request; RAM data 0xA0..0xA3; rd_ch_q=1; ch1 empty again.
- Fill ch2 with 64 writes (defaults) -> full[2]=1 after the 64th; lvl=64.
  - 65th write -> ram_we_a=0, ovf pulse next cycle, other channels unaffected.
  - One read then one write -> wrap: ram_adr_a=0x80, full again.
- Read ch0 while empty, simultaneous with a write to ch0 -> write accepted, udf=1, rd_valid=0.
  - Read in the next cycle -> returns the written word, rd_valid=1.
- Interleave ch3 writes and ch0 reads on the same cycles for 200 cycles with a scoreboard -> per-channel FIFO order preserved; no address ever outside the channel's region (0xC0..0xFF for ch3).
- Assert rst_n=0 for one cycle mid-stream with ch1 at lvl=10 and rd_valid=1 -> rd_valid drops immediately; after release ch1 is empty and lvl=0.

Source files
------------

// File: rtl/vfifo_mq_ctrl.sv
// Multi-queue controller: carves one simple dual-port RAM into 2^CH_BITS
// equal-size FIFO regions and drives its write enable and both addresses.
module vfifo_mq_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int CH_BITS    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [CH_BITS-1:0]               wr_ch,
  input  logic                             rd_en,
  input  logic [CH_BITS-1:0]               rd_ch,
  output logic                             ram_we_a,
  output logic [ADDR_WIDTH-1:0]            ram_adr_a,
  output logic [ADDR_WIDTH-1:0]            ram_adr_b,
  output logic                             rd_valid,
  output logic [CH_BITS-1:0]               rd_ch_q,
  output logic [(1<<CH_BITS)-1:0]          full,
  output logic [(1<<CH_BITS)-1:0]          empty,
  input  logic [CH_BITS-1:0]               lvl_ch,
  output logic [ADDR_WIDTH-CH_BITS:0]      lvl,
  output logic                             ovf,
  output logic                             udf
);

  localparam int NCH = 1 << CH_BITS;
  localparam int PW  = ADDR_WIDTH - CH_BITS;
  localparam logic [PW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]    r_wptr [NCH];
  logic [PW:0]    r_rptr [NCH];
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_empty;
  logic           w_wr_acc;
  logic           w_rd_acc;

  // NOTE: every signal written in an always_comb is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_empty[c] = (r_wptr[c] == r_rptr[c]);
      w_full[c]  = (r_wptr[c][PW-1:0] == r_rptr[c][PW-1:0]) &&
                   (r_wptr[c][PW] != r_rptr[c][PW]);
    end
  end

  assign full  = w_full;
  assign empty = w_empty;

  // Each request is judged against the current flags only, so a same-channel
  // write/read pair needs no special casing.
  assign w_wr_acc = rst_n & wr_en & ~w_full[wr_ch];
  assign w_rd_acc = rst_n & rd_en & ~w_empty[rd_ch];

  assign ram_we_a  = w_wr_acc;
  assign ram_adr_a = {wr_ch, r_wptr[wr_ch][PW-1:0]};
  assign ram_adr_b = {rd_ch, r_rptr[rd_ch][PW-1:0]};

  assign lvl = r_wptr[lvl_ch] - r_rptr[lvl_ch];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: only the pointer bank is reset; the RAM contents are left alone
  // because emptiness is decided solely by the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else begin
      if (w_wr_acc) r_wptr[wr_ch] <= r_wptr[wr_ch] + PTR_ONE;
      if (w_rd_acc) r_rptr[rd_ch] <= r_rptr[rd_ch] + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_ch_q  <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      rd_valid <= w_rd_acc;
      rd_ch_q  <= rd_ch;
      ovf      <= wr_en & w_full[wr_ch];
      udf      <= rd_en & w_empty[rd_ch];
    end
  end

endmodule
